// File: rtl/riio_gpi_sample_ctrl.sv
// Duty-cycled sampler for one pull-down GPI pad: gates pad IE, waits out the settle window,
// cross-checks the two redundant DI bits and debounces them into a level plus an edge pulse.
module riio_gpi_sample_ctrl #(
    parameter int PERIOD_W = 16,
    parameter int SETTLE_W = 4,
    parameter int DEB_W    = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic                cont,
    input  logic [PERIOD_W-1:0] period,
    input  logic [SETTLE_W-1:0] settle,
    input  logic [DEB_W-1:0]    deb,
    input  logic [1:0]          ste_cfg,
    output logic                ie,
    output logic [1:0]          ste,
    input  logic [1:0]          di,
    output logic                smp,
    output logic                smp_vld,
    output logic                mism,
    output logic                level,
    output logic                lvl_edge
);

    localparam int CNT_W = (PERIOD_W > SETTLE_W + 1) ? PERIOD_W : SETTLE_W + 1;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        SLEEP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   settle_ld;
    logic [CNT_W-1:0]   period_ld;
    logic               ie_nxt;
    logic [1:0]         sync_a;
    logic [1:0]         sync_b;
    logic [DEB_W-1:0]   deb_cnt;
    logic [DEB_W-1:0]   deb_inc;
    logic [DEB_W-1:0]   deb_thr;

    // Two extra settle cycles cover the DI synchronizer depth.
    assign settle_ld = CNT_W'(settle) + CNT_W'(2);
    assign period_ld = CNT_W'(period);

    assign deb_thr = (deb == '0) ? DEB_W'(1) : deb;
    assign deb_inc = (deb_cnt == '1) ? deb_cnt : deb_cnt + DEB_W'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            OFF: begin
                if (en) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = settle_ld;
                end
            end
            SETTLE: begin
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = SAMPLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (!cont) begin
                    state_nxt = SLEEP;
                    cnt_nxt   = period_ld;
                end
            end
            SLEEP: begin
                if (cnt == '0) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = settle_ld;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = OFF;
                cnt_nxt   = '0;
            end
        endcase
        if (!en) begin
            state_nxt = OFF;
            cnt_nxt   = '0;
        end
        ie_nxt = (state_nxt == SETTLE) || (state_nxt == SAMPLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= OFF;
            cnt      <= '0;
            ie       <= 1'b0;
            ste      <= 2'b00;
            sync_a   <= 2'b00;
            sync_b   <= 2'b00;
            smp      <= 1'b0;
            smp_vld  <= 1'b0;
            mism     <= 1'b0;
            level    <= 1'b0;
            lvl_edge <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ie       <= ie_nxt;
            smp_vld  <= 1'b0;
            mism     <= 1'b0;
            lvl_edge <= 1'b0;
            // STE only moves while the receiver is powered down.
            if (state == OFF || state == SLEEP) begin
                ste <= ste_cfg;
            end
            if (!en) begin
                sync_a <= 2'b00;
                sync_b <= 2'b00;
            end else begin
                sync_a <= di;
                sync_b <= sync_a;
            end
            if (state == SAMPLE) begin
                if (sync_b[0] != sync_b[1]) begin
                    mism <= 1'b1;
                end else begin
                    smp     <= sync_b[0];
                    smp_vld <= 1'b1;
                    if (sync_b[0] == level) begin
                        deb_cnt <= '0;
                    end else if (deb_inc >= deb_thr) begin
                        level    <= sync_b[0];
                        lvl_edge <= 1'b1;
                        deb_cnt  <= '0;
                    end else begin
                        deb_cnt <= deb_inc;
                    end
                end
            end
            if (!en) begin
                deb_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_riio_gpi_sample_ctrl.sv
// Directed bench for riio_gpi_sample_ctrl: settle timing, sleep period, debounce,
// mismatch handling, continuous mode with STE gating, disable and reset.
module tb_riio_gpi_sample_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        cont;
    logic [15:0] period;
    logic [3:0]  settle;
    logic [3:0]  deb;
    logic [1:0]  ste_cfg;
    logic        ie;
    logic [1:0]  ste;
    logic [1:0]  di;
    logic        smp;
    logic        smp_vld;
    logic        mism;
    logic        level;
    logic        lvl_edge;

    int n_cmp = 0;
    int n_bad = 0;

    riio_gpi_sample_ctrl #(.PERIOD_W(16), .SETTLE_W(4), .DEB_W(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .cont     (cont),
        .period   (period),
        .settle   (settle),
        .deb      (deb),
        .ste_cfg  (ste_cfg),
        .ie       (ie),
        .ste      (ste),
        .di       (di),
        .smp      (smp),
        .smp_vld  (smp_vld),
        .mism     (mism),
        .level    (level),
        .lvl_edge (lvl_edge)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance to the next cycle carrying a sample result (valid or mismatch).
    task automatic wait_result();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(smp_vld || mism) && n < 200);
        n_cmp++;
        if (!(smp_vld || mism)) begin
            n_bad++;
            $display("FAIL wait_result: no sample result within %0d cycles, need one", n);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b0; cont = 1'b0; period = 16'd10; settle = 4'd3;
        deb = 4'd1; ste_cfg = 2'b11; di = 2'b11;
        repeat (3) step();
        n_cmp++; if (ie !== 1'b0)      begin n_bad++; $display("FAIL reset_ie: got %b need 0", ie); end
        n_cmp++; if (ste !== 2'b00)    begin n_bad++; $display("FAIL reset_ste: got %b need 00", ste); end
        n_cmp++; if (smp !== 1'b0)     begin n_bad++; $display("FAIL reset_smp: got %b need 0", smp); end
        n_cmp++; if (smp_vld !== 1'b0) begin n_bad++; $display("FAIL reset_smp_vld: got %b need 0", smp_vld); end
        n_cmp++; if (mism !== 1'b0)    begin n_bad++; $display("FAIL reset_mism: got %b need 0", mism); end
        n_cmp++; if (level !== 1'b0)   begin n_bad++; $display("FAIL reset_level: got %b need 0", level); end
        n_cmp++; if (lvl_edge !== 1'b0) begin n_bad++; $display("FAIL reset_edge: got %b need 0", lvl_edge); end
        ste_cfg = 2'b01;
        rstn = 1'b1;
        step();
    endtask

    // T1: EN rises at cycle 0, IE high cycles 1-6, result at cycle 7.
    task automatic test_first_sample();
        en = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            n_cmp++;
            if (ie !== (c <= 6)) begin
                n_bad++; $display("FAIL t1_ie cycle %0d: got %b need %b", c, ie, (c <= 6));
            end
            if (c == 6) begin
                n_cmp++; if (smp_vld !== 1'b0) begin n_bad++; $display("FAIL t1_early_vld: got %b need 0", smp_vld); end
            end
        end
        n_cmp++; if (smp_vld !== 1'b1)  begin n_bad++; $display("FAIL t1_vld: got %b need 1", smp_vld); end
        n_cmp++; if (smp !== 1'b1)      begin n_bad++; $display("FAIL t1_smp: got %b need 1", smp); end
        n_cmp++; if (level !== 1'b1)    begin n_bad++; $display("FAIL t1_level: got %b need 1", level); end
        n_cmp++; if (lvl_edge !== 1'b1) begin n_bad++; $display("FAIL t1_edge: got %b need 1", lvl_edge); end
        n_cmp++; if (ste !== 2'b01)     begin n_bad++; $display("FAIL t1_ste: got %b need 01", ste); end
    endtask

    // T2: PERIOD=10 keeps IE low 11 cycles, then 5 settle + 1 sample cycles high.
    task automatic test_period();
        int n_lo;
        int n_hi;
        n_lo = 0;
        while (ie === 1'b0 && n_lo < 40) begin n_lo++; step(); end
        n_hi = 0;
        while (ie === 1'b1 && n_hi < 40) begin n_hi++; step(); end
        n_cmp++; if (n_lo != 11) begin n_bad++; $display("FAIL t2_sleep_len: got %0d need 11", n_lo); end
        n_cmp++; if (n_hi != 6)  begin n_bad++; $display("FAIL t2_awake_len: got %0d need 6", n_hi); end
        n_cmp++; if (smp_vld !== 1'b1)  begin n_bad++; $display("FAIL t2_vld: got %b need 1", smp_vld); end
        n_cmp++; if (lvl_edge !== 1'b0) begin n_bad++; $display("FAIL t2_edge: got %b need 0", lvl_edge); end
        period = 16'd2;
    endtask

    // T3: DEB=3; a two-sample glitch is rejected, three in a row flip the level.
    task automatic test_debounce();
        logic [1:0] pat [6];
        logic       exp_lvl [6];
        logic       exp_edg [6];
        pat     = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
        exp_lvl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_edg = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        deb = 4'd3;
        for (int i = 0; i < 6; i++) begin
            di = pat[i];
            wait_result();
            n_cmp++;
            if (smp !== pat[i][0]) begin n_bad++; $display("FAIL t3_smp[%0d]: got %b need %b", i, smp, pat[i][0]); end
            n_cmp++;
            if (level !== exp_lvl[i]) begin n_bad++; $display("FAIL t3_level[%0d]: got %b need %b", i, level, exp_lvl[i]); end
            n_cmp++;
            if (lvl_edge !== exp_edg[i]) begin n_bad++; $display("FAIL t3_edge[%0d]: got %b need %b", i, lvl_edge, exp_edg[i]); end
        end
    endtask

    // T4: disagreeing DI bits are flagged and discarded; DEB=0 acts as 1.
    task automatic test_mismatch();
        di = 2'b10;
        wait_result();
        n_cmp++; if (mism !== 1'b1)    begin n_bad++; $display("FAIL t4_mism: got %b need 1", mism); end
        n_cmp++; if (smp_vld !== 1'b0) begin n_bad++; $display("FAIL t4_vld: got %b need 0", smp_vld); end
        n_cmp++; if (level !== 1'b0)   begin n_bad++; $display("FAIL t4_level: got %b need 0", level); end
        n_cmp++; if (smp !== 1'b0)     begin n_bad++; $display("FAIL t4_smp_held: got %b need 0", smp); end
        di = 2'b01;
        wait_result();
        n_cmp++; if (mism !== 1'b1)    begin n_bad++; $display("FAIL t4_mism01: got %b need 1", mism); end
        di = 2'b11;
        wait_result();
        n_cmp++; if (level !== 1'b0)    begin n_bad++; $display("FAIL t4_deb3_level: got %b need 0", level); end
        n_cmp++; if (lvl_edge !== 1'b0) begin n_bad++; $display("FAIL t4_deb3_edge: got %b need 0", lvl_edge); end
        deb = 4'd0;
        wait_result();
        n_cmp++; if (level !== 1'b1)    begin n_bad++; $display("FAIL t4_deb0_level: got %b need 1", level); end
        n_cmp++; if (lvl_edge !== 1'b1) begin n_bad++; $display("FAIL t4_deb0_edge: got %b need 1", lvl_edge); end
    endtask

    // T5: continuous sampling; STE_CFG change held off until OFF.
    task automatic test_cont();
        cont = 1'b1;
        wait_result();
        ste_cfg = 2'b10;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (ie !== 1'b1)      begin n_bad++; $display("FAIL t5_ie[%0d]: got %b need 1", i, ie); end
            n_cmp++; if (smp_vld !== 1'b1) begin n_bad++; $display("FAIL t5_vld[%0d]: got %b need 1", i, smp_vld); end
            n_cmp++; if (ste !== 2'b01)    begin n_bad++; $display("FAIL t5_ste_hold[%0d]: got %b need 01", i, ste); end
            step();
        end
        en = 1'b0;
        step();
        n_cmp++; if (ie !== 1'b0)      begin n_bad++; $display("FAIL t5_off_ie: got %b need 0", ie); end
        n_cmp++; if (smp_vld !== 1'b1) begin n_bad++; $display("FAIL t5_pending_vld: got %b need 1", smp_vld); end
        n_cmp++; if (ste !== 2'b01)    begin n_bad++; $display("FAIL t5_ste_first_off: got %b need 01", ste); end
        n_cmp++; if (level !== 1'b1)   begin n_bad++; $display("FAIL t5_level_held: got %b need 1", level); end
        step();
        n_cmp++; if (ste !== 2'b10)    begin n_bad++; $display("FAIL t5_ste_loaded: got %b need 10", ste); end
        n_cmp++; if (smp_vld !== 1'b0) begin n_bad++; $display("FAIL t5_vld_stop: got %b need 0", smp_vld); end
    endtask

    // T6: disable mid-SETTLE, SETTLE=0 window, reset mid-SLEEP.
    task automatic test_disable_reset();
        int n_hi;
        cont = 1'b0;
        settle = 4'd3;
        en = 1'b1;
        step();
        step();
        n_cmp++; if (ie !== 1'b1)    begin n_bad++; $display("FAIL t6_settle_ie: got %b need 1", ie); end
        en = 1'b0;
        step();
        n_cmp++; if (ie !== 1'b0)    begin n_bad++; $display("FAIL t6_dis_ie: got %b need 0", ie); end
        n_cmp++; if (level !== 1'b1) begin n_bad++; $display("FAIL t6_dis_level: got %b need 1", level); end
        settle = 4'd0;
        en = 1'b1;
        step();
        n_hi = 0;
        while (ie === 1'b1 && n_hi < 40) begin n_hi++; step(); end
        n_cmp++; if (n_hi != 3)        begin n_bad++; $display("FAIL t6_settle0_len: got %0d need 3", n_hi); end
        n_cmp++; if (smp_vld !== 1'b1) begin n_bad++; $display("FAIL t6_settle0_vld: got %b need 1", smp_vld); end
        step();
        n_cmp++; if (ie !== 1'b0)      begin n_bad++; $display("FAIL t6_sleep_ie: got %b need 0", ie); end
        rstn = 1'b0;
        step();
        n_cmp++; if (ie !== 1'b0)      begin n_bad++; $display("FAIL t6_rst_ie: got %b need 0", ie); end
        n_cmp++; if (level !== 1'b0)   begin n_bad++; $display("FAIL t6_rst_level: got %b need 0", level); end
        n_cmp++; if (ste !== 2'b00)    begin n_bad++; $display("FAIL t6_rst_ste: got %b need 00", ste); end
        n_cmp++; if (smp !== 1'b0)     begin n_bad++; $display("FAIL t6_rst_smp: got %b need 0", smp); end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_period();
        test_debounce();
        test_mismatch();
        test_cont();
        test_disable_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
